// File: rtl/morse_message_scheduler_if.sv
// Bundle of message-source request signals and the shared blink/tone channel outputs.
// The master side drives requests and patterns; the slave side is the scheduler.
interface morse_message_scheduler_if #(
   parameter int MESSAGE_WIDTH = 84,
   parameter int NUM_REQ       = 2
);
   localparam int LW = $clog2(MESSAGE_WIDTH + 1);
   localparam int IW = $clog2(MESSAGE_WIDTH);

   logic [NUM_REQ-1:0]               REQ;
   logic [NUM_REQ*MESSAGE_WIDTH-1:0] PATTERN;
   logic [NUM_REQ*LW-1:0]            LENGTH;
   logic [NUM_REQ-1:0]               GRANT;
   logic [NUM_REQ-1:0]               DONE;
   logic                             BUSY;
   logic                             LED;
   logic                             TONE_EN;
   logic [IW-1:0]                    BIT_INDEX;

   modport master (
      output REQ, PATTERN, LENGTH,
      input  GRANT, DONE, BUSY, LED, TONE_EN, BIT_INDEX
   );

   modport slave (
      input  REQ, PATTERN, LENGTH,
      output GRANT, DONE, BUSY, LED, TONE_EN, BIT_INDEX
   );
endinterface

// File: rtl/morse_message_scheduler.sv
// Round-robin scheduler that plays one requester's bit pattern LSB-first on a shared
// LED / tone-enable channel, one bit per TICK_RATE clocks, with a silent gap between messages.
//
// state | meaning
// IDLE  | no owner; arbitrate among REQ bits
// LOAD  | owner granted; latch its pattern and length
// PLAY  | drive shadow[BIT_INDEX] on LED, advance every TICK_RATE clocks
// GAP   | silent spacing after a message or abort
module morse_message_scheduler #(
   parameter int TICK_RATE     = 2500000,
   parameter int MESSAGE_WIDTH = 84,
   parameter int NUM_REQ       = 2,
   parameter int GAP_BITS      = 7
) (
   input  logic                      CLK,
   input  logic                      RST,
   morse_message_scheduler_if.slave  bus
);
   localparam int LW      = $clog2(MESSAGE_WIDTH + 1);
   localparam int IW      = $clog2(MESSAGE_WIDTH);
   localparam int OW      = $clog2(NUM_REQ);
   localparam int TW      = $clog2(TICK_RATE + 1);
   localparam int GAP_CYC = GAP_BITS * TICK_RATE;
   localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

   localparam state_t          GAP_NEXT = (GAP_BITS == 0) ? S_IDLE : S_GAP;
   localparam logic            GAP_BUSY = (GAP_BITS != 0);
   localparam logic [GW-1:0]   GAP_LOAD = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
   localparam logic [TW-1:0]   TICK_END = TW'(TICK_RATE - 1);
   localparam logic [LW-1:0]   LEN_MAX  = LW'(MESSAGE_WIDTH);

   state_t                   state;
   logic [OW-1:0]            owner;
   logic [OW-1:0]            ptr;
   logic [TW-1:0]            tick;
   logic [GW-1:0]            gap_cnt;
   logic [MESSAGE_WIDTH-1:0] shadow;
   logic [LW-1:0]            len_q;
   logic [IW-1:0]            bit_idx;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;
   logic                     led;

   logic [OW-1:0]            pick;
   logic                     any_req;
   logic [MESSAGE_WIDTH-1:0] owner_pat;
   logic [LW-1:0]            owner_len;
   logic [LW-1:0]            len_clamped;
   logic                     owner_req;
   logic                     last_bit;
   logic [IW-1:0]            next_idx;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // First set request after the pointer, wrapping; the last winner is searched last.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!any_req && bus.REQ[(int'(ptr) + k) % NUM_REQ]) begin
            any_req = 1'b1;
            pick    = OW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      owner_pat   = bus.PATTERN[int'(owner)*MESSAGE_WIDTH +: MESSAGE_WIDTH];
      owner_len   = bus.LENGTH[int'(owner)*LW +: LW];
      len_clamped = (owner_len > LEN_MAX) ? LEN_MAX : owner_len;
      owner_req   = bus.REQ[owner];
      last_bit    = (LW'(bit_idx) + LW'(1)) == len_q;
      next_idx    = bit_idx + IW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         owner   <= '0;
         ptr     <= OW'(NUM_REQ - 1);
         tick    <= '0;
         gap_cnt <= '0;
         shadow  <= '0;
         len_q   <= '0;
         bit_idx <= '0;
         grant   <= '0;
         done    <= '0;
         busy    <= 1'b0;
         led     <= 1'b0;
      end else begin
         done <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  owner <= pick;
                  ptr   <= pick;
                  grant <= onehot(pick);
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               shadow  <= owner_pat;
               len_q   <= len_clamped;
               tick    <= '0;
               bit_idx <= '0;
               if (len_clamped == '0) begin
                  done    <= onehot(owner);
                  grant   <= '0;
                  busy    <= GAP_BUSY;
                  gap_cnt <= GAP_LOAD;
                  state   <= GAP_NEXT;
               end else begin
                  led   <= owner_pat[0];
                  state <= S_PLAY;
               end
            end
            S_PLAY: begin
               // A dropped request takes precedence over a completing last bit.
               if (!owner_req) begin
                  grant   <= '0;
                  led     <= 1'b0;
                  tick    <= '0;
                  bit_idx <= '0;
                  busy    <= GAP_BUSY;
                  gap_cnt <= GAP_LOAD;
                  state   <= GAP_NEXT;
               end else if (tick == TICK_END) begin
                  tick <= '0;
                  if (last_bit) begin
                     done    <= onehot(owner);
                     grant   <= '0;
                     led     <= 1'b0;
                     bit_idx <= '0;
                     busy    <= GAP_BUSY;
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP_NEXT;
                  end else begin
                     bit_idx <= next_idx;
                     led     <= shadow[next_idx];
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.GRANT     = grant;
   assign bus.DONE      = done;
   assign bus.BUSY      = busy;
   assign bus.LED       = led;
   assign bus.TONE_EN   = led;
   assign bus.BIT_INDEX = bit_idx;
endmodule
